addsub_issue_ctrl: RTL and testbench

//  Sequential issue/capture stage around the 16-bit adder/subtractor (adder_sub16bit).

---
 rtl/addsub_issue_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_addsub_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_issue_ctrl.sv
// ---------------------------------------------------------------------------
// addsub_issue_ctrl
//
// Issue/capture stage wrapped around an external 16-bit adder/subtractor.
// An operation is accepted over a valid/ready handshake and its operands are
// registered onto the adder inputs. One cycle later the adder sum/carry-out
// are captured together with derived flags (carry, signed overflow, zero,
// negative), and the result is held until the consumer accepts it. A
// result accumulator lets operand A be taken from the previous result so
// add/sub operations can be chained.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   acc_clr                  synchronous clear of the accumulator
//   in_valid / in_ready      upstream handshake
//   in_a, in_b, in_op        operands and op select (0 = A+B, 1 = A-B)
//   in_acc                   take operand A from the accumulator
//   add_a, add_b, add_op     registered operands driven to the adder
//   add_sum, add_cout        adder outputs
//   out_valid / out_ready    downstream handshake
//   out_result               captured sum
//   out_carry                captured carry-out (subtract: 1 = no borrow)
//   out_ovf, out_zero,
//   out_neg                  signed overflow, result == 0, result sign bit
// ---------------------------------------------------------------------------
module addsub_issue_ctrl #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   ACC_RESET = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_acc,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Signed overflow of a two's-complement add or subtract, judged from the
    // operand and result sign bits only.
    function automatic logic calc_ovf(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] s,
        input logic             op
    );
        logic ovf;
        if (op == 1'b0) begin
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
        return ovf;
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] acc_cap_s;
    logic [WIDTH-1:0] add_a_q,     add_a_d;
    logic [WIDTH-1:0] add_b_q,     add_b_d;
    logic             add_op_q,    add_op_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_q,     carry_d;
    logic             ovf_q,       ovf_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    // Next-state, operand issue, result capture and accumulator update.
    always_comb begin
        state_d   = state_q;
        acc_cap_s = acc_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_op_d  = add_op_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        neg_d     = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // acc_q is the pre-clear value even when acc_clr is high now.
                    add_a_d  = in_acc ? acc_q : in_a;
                    add_b_d  = in_b;
                    add_op_d = in_op;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Adder has had a full cycle to settle from the registered operands.
                result_d  = add_sum;
                carry_d   = add_cout;
                ovf_d     = calc_ovf(add_a_q, add_b_q, add_sum, add_op_q);
                zero_d    = (add_sum == {WIDTH{1'b0}});
                neg_d     = add_sum[WIDTH-1];
                acc_cap_s = add_sum;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear in the capture cycle beats the captured sum.
        acc_d = acc_clr ? ACC_RESET : acc_cap_s;

        // Handshake outputs are registered, so derive them from the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_RESET;
            add_a_q     <= {WIDTH{1'b0}};
            add_b_q     <= {WIDTH{1'b0}};
            add_op_q    <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_op_q    <= add_op_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_op     = add_op_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addsub_issue_ctrl
//
// Self-checking bench for addsub_issue_ctrl. A behavioural 16-bit
// adder/subtractor is wired to the add_* ports. Expected results come from
// plain integer arithmetic over the operation's rules and a scalar
// accumulator model. Directed cases cover overflow, equal-subtract,
// accumulate chains, backpressure and reset mid-operation; a randomized
// loop follows.
// ---------------------------------------------------------------------------
module tb_addsub_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic        in_acc;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_op;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned ref_acc  = 0;

    always #5 clk = ~clk;

    // Behavioural adder/subtractor (subtract as a + ~b + 1, cout = no borrow).
    assign {add_cout, add_sum} = add_op ? ({1'b0, add_a} + {1'b0, ~add_b} + 17'd1)
                                        : ({1'b0, add_a} + {1'b0, add_b});

    addsub_issue_ctrl #(.WIDTH(16), .ACC_RESET(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_clr    (acc_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_op     (add_op),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    task automatic ref_calc(input int unsigned a, input int unsigned b, input bit op,
                            output int unsigned res, output bit c, output bit v,
                            output bit z, output bit n);
        int sa, sb, ss;
        if (!op) begin
            res = (a + b) % 65536;
            c   = (a + b) > 65535;
        end else begin
            res = (a + 65536 - b) % 65536;
            c   = (a >= b);
        end
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        ss = op ? sa - sb : sa + sb;
        v  = (ss > 32767) || (ss < -32768);
        z  = (res == 0);
        n  = (res >= 32768);
    endtask

    // Issue one operation, check the registered operands, the captured result
    // one cycle later, stability under `hold` cycles of backpressure, and the
    // return to IDLE after acceptance.
    task automatic do_op(input int unsigned a, input int unsigned b, input bit op,
                         input bit acc, input bit clr_issue, input bit clr_exec,
                         input int hold);
        int unsigned opa, res;
        bit c, v, z, n;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a[15:0];
        in_b     = b[15:0];
        in_op    = op;
        in_acc   = acc;
        acc_clr  = clr_issue;
        opa      = acc ? ref_acc : a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_acc   = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        acc_clr  = clr_exec;
        chk("add_a", add_a, opa);
        chk("add_b", add_b, b);
        chk("add_op", add_op, op);
        chk("exec_in_ready", in_ready, 0);
        chk("exec_out_valid", out_valid, 0);
        ref_calc(opa, b, op, res, c, v, z, n);
        ref_acc = clr_exec ? 0 : res;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("out_valid", out_valid, 1);
        chk("result", out_result, res);
        chk("flags_cvzn", {out_carry, out_ovf, out_zero, out_neg}, {c, v, z, n});
        chk("hold_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, res);
            chk("bp_flags", {out_carry, out_ovf, out_zero, out_neg}, {c, v, z, n});
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("acc_valid_drop", out_valid, 0);
        chk("acc_in_ready", in_ready, 1);
        chk("acc_result_held", out_result, res);
        chk("acc_add_a_held", add_a, opa);
    endtask

    task automatic clear_acc();
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        ref_acc = 0;
    endtask

    // Reset asserted during EXEC: the operation must vanish.
    task automatic reset_mid_op(input int unsigned a, input int unsigned b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a[15:0];
        in_b     = b[15:0];
        in_op    = 1'b0;
        in_acc   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_exec", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", out_result, 0);
        chk("rst_add_a", add_a, 0);
        ref_acc = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end
    endtask

    function automatic int unsigned pick16();
        int unsigned edges [4] = '{32'h7FFF, 32'h8000, 32'hFFFF, 32'h0000};
        if ($urandom_range(0, 3) == 0) begin
            return edges[$urandom_range(0, 3)];
        end
        return $urandom_range(0, 65535);
    endfunction

    initial begin
        rst       = 1'b1;
        acc_clr   = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_op     = 1'b0;
        in_acc    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", out_result, 0);
        chk("reset_flags", {out_carry, out_ovf, out_zero, out_neg}, 0);
        chk("reset_add", {add_a, add_b, add_op}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // Directed cases
        do_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // add overflow
        do_op(32'h0005, 32'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // sub equal
        do_op(32'h8000, 32'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // sub overflow
        clear_acc();
        do_op(32'hABCD, 32'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 0);   // 0003
        do_op(32'hABCD, 32'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 0);   // 0006
        do_op(32'hABCD, 32'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 0);   // 0009
        do_op(32'hABCD, 32'h000A, 1'b1, 1'b1, 1'b0, 1'b0, 0);   // FFFF
        do_op(32'h1234, 32'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 5);   // backpressure
        do_op(32'h0000, 32'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 0);   // clr on acc issue
        do_op(32'h0000, 32'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 0);   // clr wins at capture
        do_op(32'h0000, 32'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 0);   // acc must be 0 here
        reset_mid_op(32'h1111, 32'h2222);
        do_op(32'h5555, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0);   // acc back to reset value

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            do_op(pick16(), pick16(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
